// File: rtl/serial_word_receiver_pkg.sv
// Shared definitions for the serial word link: default sizes and FSM state encoding.
package serial_word_receiver_pkg;

    localparam int unsigned DEF_WIDTH     = 32;
    localparam int unsigned DEF_SEL_WIDTH = 6;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/serial_word_receiver_collector.sv
// Shift register, direction mux and bit counter for one serial word.
// done_o flags the cycle in which the final bit of a word is being shifted in.
module serial_shift_collector
    import serial_word_receiver_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic             dir_i,
    input  logic             serial_i,
    output logic [WIDTH-1:0] shift_o,
    output logic [WIDTH-1:0] next_o,
    output logic             done_o
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic [WIDTH-1:0] shift_q;
    logic [CW-1:0]    count_q;

    // Next shift value for the latched direction and completion detect.
    always_comb begin
        next_o = shift_q;
        if (dir_i) begin
            next_o = {shift_q[WIDTH-2:0], serial_i};
        end else begin
            next_o = {serial_i, shift_q[WIDTH-1:1]};
        end
        done_o = enable_i && (count_q == CW'(WIDTH - 1));
    end

    // Shift register and bit counter; counter wraps to zero on the last bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q <= {WIDTH{1'b0}};
            count_q <= {CW{1'b0}};
        end else if (clear_i) begin
            shift_q <= {WIDTH{1'b0}};
            count_q <= {CW{1'b0}};
        end else if (enable_i) begin
            shift_q <= next_o;
            count_q <= done_o ? {CW{1'b0}} : (count_q + CW'(1));
        end
    end

    assign shift_o = shift_q;

endmodule

// File: rtl/serial_word_receiver.sv
// Serial word receiver: control FSM, one-word output slot with valid/ready,
// and overrun reporting around the shift collector.
module serial_word_receiver
    import serial_word_receiver_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned SEL_WIDTH = DEF_SEL_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [SEL_WIDTH-1:0] sel_in,
    input  logic                 msb_first,
    input  logic                 abort,
    input  logic                 bit_valid,
    input  logic                 serial_in,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     data_out,
    output logic [SEL_WIDTH-1:0] sel_out,
    output logic                 out_valid,
    output logic                 busy,
    output logic                 overrun
);

    state_e               state_q, state_d;
    logic [SEL_WIDTH-1:0] tag_q, tag_d;
    logic                 dir_q, dir_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic [SEL_WIDTH-1:0] sel_q, sel_d;
    logic                 valid_q, valid_d;
    logic                 overrun_q, overrun_d;

    logic                 clear_s;
    logic                 enable_s;
    logic                 done_s;
    logic                 slot_free_s;
    logic [WIDTH-1:0]     shift_s;
    logic [WIDTH-1:0]     next_s;

    serial_shift_collector #(.WIDTH(WIDTH)) u_collector (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (clear_s),
        .enable_i (enable_s),
        .dir_i    (dir_q),
        .serial_i (serial_in),
        .shift_o  (shift_s),
        .next_o   (next_s),
        .done_o   (done_s)
    );

    // The slot can take a new word if it is empty or drains on this edge.
    assign slot_free_s = !valid_q || out_ready;

    // Next-state, slot loading and overrun decode.
    always_comb begin
        state_d   = state_q;
        tag_d     = tag_q;
        dir_d     = dir_q;
        data_d    = data_q;
        sel_d     = sel_q;
        valid_d   = valid_q && !out_ready;
        overrun_d = 1'b0;
        clear_s   = 1'b0;
        enable_s  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_SHIFT;
                    clear_s = 1'b1;
                    tag_d   = sel_in;
                    dir_d   = msb_first;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    state_d = S_IDLE;
                    clear_s = 1'b1;
                end else begin
                    overrun_d = start;
                    enable_s  = bit_valid;
                    if (done_s && slot_free_s) begin
                        data_d  = next_s;
                        sel_d   = tag_q;
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                    end else if (done_s) begin
                        state_d = S_HOLD;
                    end else begin
                        state_d = S_SHIFT;
                    end
                end
            end
            S_HOLD: begin
                if (abort) begin
                    state_d = S_IDLE;
                    clear_s = 1'b1;
                end else begin
                    overrun_d = start;
                    if (slot_free_s) begin
                        data_d  = shift_s;
                        sel_d   = tag_q;
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_HOLD;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                clear_s = 1'b1;
            end
        endcase
    end

    // State, latched request fields, output slot and overrun pulse registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            tag_q     <= {SEL_WIDTH{1'b0}};
            dir_q     <= 1'b0;
            data_q    <= {WIDTH{1'b0}};
            sel_q     <= {SEL_WIDTH{1'b0}};
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tag_q     <= tag_d;
            dir_q     <= dir_d;
            data_q    <= data_d;
            sel_q     <= sel_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign data_out  = data_q;
    assign sel_out   = sel_q;
    assign out_valid = valid_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_serial_word_receiver.sv
// Scoreboard bench for serial_word_receiver: directed scenarios plus random words,
// expected words queued at issue time and checked by an independent output monitor.
module tb_serial_word_receiver;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  sel_in = 6'd0;
    logic        msb_first = 1'b0;
    logic        abort = 1'b0;
    logic        bit_valid = 1'b0;
    logic        serial_in = 1'b0;
    logic        out_ready;
    logic [31:0] data_out;
    logic [5:0]  sel_out;
    logic        out_valid;
    logic        busy;
    logic        overrun;

    int total = 0;
    int bad = 0;
    logic [37:0] exp_q[$];
    bit rnd_mode = 1'b0;
    logic ready_fix = 1'b1;

    serial_word_receiver dut (
        .clk(clk), .reset(reset), .start(start), .sel_in(sel_in),
        .msb_first(msb_first), .abort(abort), .bit_valid(bit_valid),
        .serial_in(serial_in), .out_ready(out_ready), .data_out(data_out),
        .sel_out(sel_out), .out_valid(out_valid), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Consumer ready: fixed level or random per cycle.
    always @(posedge clk) begin
        #1;
        out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : ready_fix;
    end
    initial out_ready = 1'b1;

    // Output monitor: checks every handshake against the scoreboard and slot stability.
    logic        prev_stall = 1'b0;
    logic [37:0] prev_word;
    always @(negedge clk) begin
        if (prev_stall) begin
            chk("stall_valid", {63'd0, out_valid}, 64'd1);
            chk("stall_stable", {26'd0, sel_out, data_out}, {26'd0, prev_word});
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", {26'd0, sel_out, data_out}, 64'd0);
            end else begin
                chk("word", {26'd0, sel_out, data_out}, {26'd0, exp_q.pop_front()});
            end
        end
        prev_stall = out_valid && !out_ready && reset;
        prev_word  = {sel_out, data_out};
    end

    // gap: 0 none, 1 alternate idle cycle, 2 random idle cycles.
    task automatic send_word(input logic [5:0] s, input logic [31:0] w, input logic msb,
                             input int gap, input int nbits, input int ovr_at, input bit push);
        start = 1'b1; sel_in = s; msb_first = msb;
        @(posedge clk); #1;
        start = 1'b0; sel_in = 6'($urandom); msb_first = 1'($urandom);
        if (push) exp_q.push_back({s, w});
        for (int i = 0; i < nbits; i++) begin
            if ((gap == 1 && i > 0) || (gap == 2 && $urandom_range(0, 2) == 0)) begin
                bit_valid = 1'b0; serial_in = 1'($urandom);
                @(posedge clk); #1;
            end
            bit_valid = 1'b1;
            serial_in = msb ? w[31-i] : w[i];
            start = (i == ovr_at);
            @(posedge clk); #1;
            start = 1'b0; bit_valid = 1'b0; serial_in = 1'($urandom);
            if (i == ovr_at) chk("overrun_pulse", {63'd0, overrun}, 64'd1);
            else if (i == ovr_at + 1) chk("overrun_single", {63'd0, overrun}, 64'd0);
        end
    endtask

    task automatic drain(input int bound);
        for (int c = 0; c < bound && exp_q.size() > 0; c++) @(posedge clk);
        #1;
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_data", {32'd0, data_out}, 64'd0);
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1;

        // 1: reset mid-word
        send_word(6'd7, 32'h0BAD_F00D, 1'b1, 0, 10, -5, 1'b0);
        chk("mid_busy", {63'd0, busy}, 64'd1);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("r1_busy", {63'd0, busy}, 64'd0);
        chk("r1_valid", {63'd0, out_valid}, 64'd0);
        chk("r1_out", {26'd0, sel_out, data_out}, 64'd0);
        chk("r1_ovr", {63'd0, overrun}, 64'd0);
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1;
        send_word(6'd3, 32'hCAFE_1234, 1'b1, 0, 32, -5, 1'b1);
        drain(10);

        // 2: MSB first, latency
        send_word(6'd0, 32'hA5C3_0F81, 1'b1, 0, 32, -5, 1'b1);
        chk("lat_valid", {63'd0, out_valid}, 64'd1);
        chk("lat_busy", {63'd0, busy}, 64'd0);
        chk("lat_data", {32'd0, data_out}, 64'hA5C3_0F81);
        drain(10);

        // 3: LSB first with gaps
        send_word(6'd24, 32'h1234_5678, 1'b0, 1, 32, -5, 1'b1);
        drain(10);

        // 4: back-pressure
        ready_fix = 1'b0;
        @(posedge clk); #1;
        send_word(6'd1, 32'hFFFF_0000, 1'b1, 0, 32, -5, 1'b1);
        @(posedge clk); #1;
        send_word(6'd2, 32'h0000_FFFF, 1'b0, 0, 32, -5, 1'b1);
        chk("hold_busy", {63'd0, busy}, 64'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_busy2", {63'd0, busy}, 64'd1);
        chk("hold_data", {32'd0, data_out}, 64'hFFFF_0000);
        chk("hold_sel", {58'd0, sel_out}, 64'd1);
        ready_fix = 1'b1;
        drain(20);
        chk("bp_idle", {63'd0, busy}, 64'd0);

        // 5: abort
        send_word(6'd9, 32'h5555_AAAA, 1'b1, 0, 20, -5, 1'b0);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        send_word(6'd9, 32'h7777_0000, 1'b0, 0, 3, -5, 1'b0);
        abort = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; start = 1'b0;
        chk("abst_busy", {63'd0, busy}, 64'd0);
        chk("abst_ovr", {63'd0, overrun}, 64'd0);
        abort = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; start = 1'b0;
        chk("abst_idle_busy", {63'd0, busy}, 64'd0);
        send_word(6'd33, 32'hDEAD_BEEF, 1'b1, 0, 32, -5, 1'b1);
        drain(10);

        // 6: overrun at bit 5
        send_word(6'd63, 32'h8000_0001, 1'b0, 0, 32, 5, 1'b1);
        drain(10);

        // Random words with random gaps, direction and consumer stalls
        rnd_mode = 1'b1;
        for (int k = 0; k < 12; k++) begin
            for (int c = 0; c < 200 && busy; c++) @(posedge clk);
            #1;
            send_word(6'($urandom), 32'($urandom), 1'($urandom), 2, 32, -5, 1'b1);
        end
        rnd_mode = 1'b0;
        drain(100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
